rsa_modexp_seq: RTL and testbench
=================================

Name: rsa_modexp_seq

Overview:
- Top-level sequencer for RSA decryption: C^E mod M by left-to-right square-and-multiply in the Montgomery domain.
- Sequences two external datapath units over start/done handshakes:
  - constant_r_t_new, which produces R mod M and R^2 mod M;
  - a Montgomery multiplier, which computes a*b*R^-1 mod M.
- Latches the operands, muxes multiplier inputs, iterates over exponent bits and returns the plain-domain result.

Parameters:
- W, 1024, modulus/operand width in bits (R = 2^W).
- E_W, 1024, exponent width in bits.
- CNT_W, 11, bit-counter width; must be at least clog2(E_W)+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- M_in  in  W  modulus (odd), latched on accepted start.
- C_in  in  W  ciphertext, C_in < M_in, latched on accepted start.
- E_in  in  E_W  exponent, latched on accepted start.
- M_r  out  W  latched modulus, driven to both units.
- const_start  out  1  one-cycle pulse to constant unit.
- const_done  in  1  constant unit finished.
- R_r  in  W  R mod M from constant unit.
- R_t  in  W  R^2 mod M from constant unit.
- mm_start  out  1  one-cycle pulse to Montgomery multiplier.
- mm_a  out  W  multiplier operand A.
- mm_b  out  W  multiplier operand B.
- mm_done  in  1  multiplier finished.
- mm_res  in  W  multiplier result.
- result  out  W  C^E mod M; holds until next accepted start.
- busy  out  1  high from the cycle after an accepted start through FIN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - result, M_r, mm_a, mm_b, internal registers = 0.
  - const_start, mm_start, busy, done = 0.
  - Reset mid-operation abandons the job; late const_done or mm_done are then ignored.
- State machine: IDLE, C_REQ, C_WAIT, TOMONT, SQR, MUL, FROMMONT, FIN. Each multiplier state has a REQ and a WAIT sub-phase.
- IDLE:
  - On start: latch M/C/E, set bit index i = E_W-1, go to C_REQ.
  - start is ignored in every other state.
- C_REQ: assert const_start for 1 cycle, go to C_WAIT.
- C_WAIT: on const_done, latch one_m = R_r and r2 = R_t, go to TOMONT.
- Multiplier request/wait phases (all mm states):
  - REQ: drive mm_a/mm_b and pulse mm_start for 1 cycle.
  - mm_a/mm_b stay stable until mm_done.
  - WAIT: on mm_done, latch mm_res into the target register.
  - mm_done sampled in REQ or outside a WAIT phase is ignored.
- Operation steps:
  - TOMONT: mm(C, r2) -> cm. acc = one_m. Go to SQR.
  - SQR: mm(acc, acc) -> acc. If E[i]=1 go to MUL, else go to step.
  - MUL: mm(acc, cm) -> acc, then go to step.
  - step: if i==0 go to FROMMONT, else i = i-1 and go to SQR.
  - FROMMONT: mm(acc, 1) -> result register. Go to FIN.
  - FIN: done=1 for 1 cycle, busy falls, return to IDLE. start in FIN is ignored.
- All E_W bits are processed; there is no leading-zero skip.
- Multiplier operation count is exactly 1 + E_W + popcount(E) + 1.
- E=0: result = 1 (the FROMMONT of R mod M).
- const_start and mm_start are never high in the same cycle.
- Between any two start pulses, at most one request is outstanding.
- Constant unit and multiplier latencies are arbitrary, at least 1 cycle; the sequencer adds 1 cycle per REQ/WAIT transition.

Decomposition:
- Shared package rsa_pkg holds:
  - state enum;
  - operand-select enum (SEL_ACC, SEL_CM, SEL_C, SEL_R2, SEL_ONE);
  - default W / E_W constants.
- One sub-module: rsa_mm_opmux, a registered mm_a/mm_b select driven by the FSM.
- The FSM and bit counter stay in rsa_modexp_seq.

Test Plan:
- Setup for all scenarios:
  - W=8, E_W=8, M=187.
  - Behavioural constant unit returns R_r=69, R_t=86 after 5 cycles.
  - Behavioural Montgomery model has latency 3.
- C=2, E=8'h07 -> result=128, done pulses once, exactly 13 mm_start pulses, 1 const_start.
- C=5, E=8'h03 -> result=125; E=8'h00 -> result=1 with exactly 10 mm_start pulses.
- start re-pulsed while busy, plus a spurious mm_done during C_WAIT -> both ignored; result of the first job unchanged (128).
- rst asserted during SQR of a job with E=8'hFF:
  - outputs read 0 in the same cycle; FSM in IDLE;
  - a new job C=2, E=8'h07 then completes with result=128.
- Random multiplier latency 1..20:
  - mm_a/mm_b constant from each mm_start until its mm_done;
  - busy high exactly from the cycle after start until done.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation sequencer.
//   state_t : sequencer states; each multiplier step is split into a REQ
//             phase (operands valid, mm_start pulsed) and a WAIT phase
//             (waiting for mm_done).
//   sel_t   : operand sources for the Montgomery multiplier inputs.
//   W_DEF / E_W_DEF / CNT_W_DEF : default operand, exponent and counter widths.
package rsa_pkg;

    localparam int W_DEF     = 1024;
    localparam int E_W_DEF   = 1024;
    localparam int CNT_W_DEF = 11;

    typedef enum logic [3:0] {
        IDLE,
        C_REQ,
        C_WAIT,
        TM_REQ,
        TM_WAIT,
        SQ_REQ,
        SQ_WAIT,
        MU_REQ,
        MU_WAIT,
        FM_REQ,
        FM_WAIT,
        FIN
    } state_t;

    typedef enum logic [2:0] {
        SEL_ACC,
        SEL_CM,
        SEL_C,
        SEL_R2,
        SEL_ONE
    } sel_t;

endpackage

// File: rtl/rsa_mm_opmux.sv
// Registered operand select for the Montgomery multiplier.
// On load, each lane captures the source chosen by its select; otherwise the
// lanes hold, so the operands stay stable for the whole multiply.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           capture new operands this cycle
//   sel_a, sel_b   source selects for operand A / operand B
//   acc, cm, c, r2 candidate sources (the sequencer passes next-state values
//                  so a result written this cycle can feed the next multiply)
//   mm_a, mm_b     registered multiplier operands
module rsa_mm_opmux
    import rsa_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  sel_t         sel_a,
    input  sel_t         sel_b,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] cm,
    input  logic [W-1:0] c,
    input  logic [W-1:0] r2,
    output logic [W-1:0] mm_a,
    output logic [W-1:0] mm_b
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            sel_t         lane_sel;
            logic [W-1:0] lane_next;
            logic [W-1:0] lane_reg;

            assign lane_sel = (gi == 0) ? sel_a : sel_b;

            always_comb begin
                lane_next = '0;
                case (lane_sel)
                    SEL_ACC: lane_next = acc;
                    SEL_CM:  lane_next = cm;
                    SEL_C:   lane_next = c;
                    SEL_R2:  lane_next = r2;
                    SEL_ONE: lane_next = W'(1);
                    default: lane_next = '0;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (load) begin
                    lane_reg <= lane_next;
                end
            end
        end
    endgenerate

    assign mm_a = g_lane[0].lane_reg;
    assign mm_b = g_lane[1].lane_reg;

endmodule

// File: rtl/rsa_modexp_seq.sv
// RSA decryption sequencer: result = C^E mod M by left-to-right
// square-and-multiply in the Montgomery domain.
// Drives an external constant unit (R mod M, R^2 mod M) and an external
// Montgomery multiplier (a*b*R^-1 mod M) over start/done handshakes.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, M_in, C_in, E_in  job request and operands (accepted in IDLE only)
//   M_r                      latched modulus for both units
//   const_start/const_done   constant-unit handshake, R_r / R_t its results
//   mm_start/mm_done         multiplier handshake, mm_a/mm_b/mm_res its data
//   result, busy, done       plain-domain result and job status
module rsa_modexp_seq
    import rsa_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int E_W   = E_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   M_in,
    input  logic [W-1:0]   C_in,
    input  logic [E_W-1:0] E_in,
    output logic [W-1:0]   M_r,
    output logic           const_start,
    input  logic           const_done,
    input  logic [W-1:0]   R_r,
    input  logic [W-1:0]   R_t,
    output logic           mm_start,
    output logic [W-1:0]   mm_a,
    output logic [W-1:0]   mm_b,
    input  logic           mm_done,
    input  logic [W-1:0]   mm_res,
    output logic [W-1:0]   result,
    output logic           busy,
    output logic           done
);

    localparam int IDX_W = (E_W > 1) ? $clog2(E_W) : 1;

    state_t         state_reg,  state_next;
    logic [W-1:0]   m_reg,      m_next;
    logic [W-1:0]   c_reg,      c_next;
    logic [E_W-1:0] e_reg,      e_next;
    logic [W-1:0]   one_m_reg,  one_m_next;
    logic [W-1:0]   r2_reg,     r2_next;
    logic [W-1:0]   cm_reg,     cm_next;
    logic [W-1:0]   acc_reg,    acc_next;
    logic [W-1:0]   result_reg, result_next;
    logic [CNT_W-1:0] i_reg,    i_next;

    logic op_load;
    sel_t sel_a;
    sel_t sel_b;
    logic do_step;
    logic e_bit;

    assign e_bit = e_reg[i_reg[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            m_reg      <= '0;
            c_reg      <= '0;
            e_reg      <= '0;
            one_m_reg  <= '0;
            r2_reg     <= '0;
            cm_reg     <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            i_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            m_reg      <= m_next;
            c_reg      <= c_next;
            e_reg      <= e_next;
            one_m_reg  <= one_m_next;
            r2_reg     <= r2_next;
            cm_reg     <= cm_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            i_reg      <= i_next;
        end
    end

    // Operands for a REQ phase are loaded on the transition into it, so the
    // mux sees next-state register values (a result latched this cycle is
    // already the operand of the following multiply).
    always_comb begin
        state_next  = state_reg;
        m_next      = m_reg;
        c_next      = c_reg;
        e_next      = e_reg;
        one_m_next  = one_m_reg;
        r2_next     = r2_reg;
        cm_next     = cm_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        i_next      = i_reg;
        op_load     = 1'b0;
        sel_a       = SEL_ACC;
        sel_b       = SEL_ACC;
        do_step     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next     = M_in;
                    c_next     = C_in;
                    e_next     = E_in;
                    i_next     = CNT_W'(E_W - 1);
                    state_next = C_REQ;
                end
            end
            C_REQ: state_next = C_WAIT;
            C_WAIT: begin
                if (const_done) begin
                    one_m_next = R_r;
                    r2_next    = R_t;
                    op_load    = 1'b1;
                    sel_a      = SEL_C;
                    sel_b      = SEL_R2;
                    state_next = TM_REQ;
                end
            end
            TM_REQ: begin
                // Accumulator starts as 1 in the Montgomery domain.
                acc_next   = one_m_reg;
                state_next = TM_WAIT;
            end
            TM_WAIT: begin
                if (mm_done) begin
                    cm_next    = mm_res;
                    op_load    = 1'b1;
                    sel_a      = SEL_ACC;
                    sel_b      = SEL_ACC;
                    state_next = SQ_REQ;
                end
            end
            SQ_REQ: state_next = SQ_WAIT;
            SQ_WAIT: begin
                if (mm_done) begin
                    acc_next = mm_res;
                    if (e_bit) begin
                        op_load    = 1'b1;
                        sel_a      = SEL_ACC;
                        sel_b      = SEL_CM;
                        state_next = MU_REQ;
                    end else begin
                        do_step = 1'b1;
                    end
                end
            end
            MU_REQ: state_next = MU_WAIT;
            MU_WAIT: begin
                if (mm_done) begin
                    acc_next = mm_res;
                    do_step  = 1'b1;
                end
            end
            FM_REQ: state_next = FM_WAIT;
            FM_WAIT: begin
                if (mm_done) begin
                    result_next = mm_res;
                    state_next  = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Advance to the next exponent bit, or leave the Montgomery domain
        // (multiply by plain 1) once bit 0 has been handled.
        if (do_step) begin
            op_load = 1'b1;
            sel_a   = SEL_ACC;
            if (i_reg == '0) begin
                sel_b      = SEL_ONE;
                state_next = FM_REQ;
            end else begin
                sel_b      = SEL_ACC;
                i_next     = i_reg - CNT_W'(1);
                state_next = SQ_REQ;
            end
        end
    end

    rsa_mm_opmux #(.W(W)) u_opmux (
        .clk   (clk),
        .rst   (rst),
        .load  (op_load),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .acc   (acc_next),
        .cm    (cm_next),
        .c     (c_reg),
        .r2    (r2_next),
        .mm_a  (mm_a),
        .mm_b  (mm_b)
    );

    assign const_start = (state_reg == C_REQ);
    assign mm_start    = (state_reg == TM_REQ) || (state_reg == SQ_REQ) ||
                         (state_reg == MU_REQ) || (state_reg == FM_REQ);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == FIN);
    assign result      = result_reg;
    assign M_r         = m_reg;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Self-checking bench for rsa_modexp_seq with W=8, E_W=8, M=187.
// Behavioural constant unit and Montgomery multiplier respond to the DUT;
// expected results come from plain repeated modular multiplication.
module tb_rsa_modexp_seq;

    localparam int W     = 8;
    localparam int E_W   = 8;
    localparam int CNT_W = 4;
    localparam int MOD   = 187;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   M_in = '0;
    logic [W-1:0]   C_in = '0;
    logic [E_W-1:0] E_in = '0;
    logic [W-1:0]   M_r;
    logic           const_start;
    logic           const_done;
    logic [W-1:0]   R_r;
    logic [W-1:0]   R_t;
    logic           mm_start;
    logic [W-1:0]   mm_a;
    logic [W-1:0]   mm_b;
    logic           mm_done;
    logic           mm_done_m;
    logic           mm_spur = 1'b0;
    logic [W-1:0]   mm_res;
    logic [W-1:0]   result;
    logic           busy;
    logic           done;

    assign mm_done = mm_done_m | mm_spur;

    always #5 clk = ~clk;

    rsa_modexp_seq #(.W(W), .E_W(E_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .M_in        (M_in),
        .C_in        (C_in),
        .E_in        (E_in),
        .M_r         (M_r),
        .const_start (const_start),
        .const_done  (const_done),
        .R_r         (R_r),
        .R_t         (R_t),
        .mm_start    (mm_start),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_done     (mm_done),
        .mm_res      (mm_res),
        .result      (result),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;
    bit lat_rand = 1'b0;

    // Counters each owned by exactly one process; the main flow diffs them.
    int mm_pulses   = 0;
    int cs_pulses   = 0;
    int done_pulses = 0;
    int overlap     = 0;
    int stab_bad    = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Plain-domain reference: C^E mod M by repeated multiplication.
    function automatic int ref_modexp(input int c, input int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = (r * c) % MOD;
        return int'(r);
    endfunction

    // Pulse monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (mm_start === 1'b1)    mm_pulses++;
            if (const_start === 1'b1) cs_pulses++;
            if (done === 1'b1)        done_pulses++;
            if (mm_start === 1'b1 && const_start === 1'b1) overlap++;
        end
    end

    // Behavioural constant unit: R mod M = 69, R^2 mod M = 86 after 5 cycles.
    initial begin
        bit abort;
        const_done = 1'b0;
        R_r = '0;
        R_t = '0;
        forever begin
            @(negedge clk);
            if (const_start === 1'b1 && !rst) begin
                abort = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    if (rst) abort = 1'b1;
                end
                if (!abort) begin
                    #1;
                    const_done = 1'b1;
                    R_r = 8'd69;
                    R_t = 8'd86;
                    @(posedge clk);
                    #1;
                    const_done = 1'b0;
                end
            end
        end
    end

    // Behavioural Montgomery multiplier: a*b*R^-1 mod M, latency 3 or random.
    initial begin
        int rinv;
        int lat;
        bit abort;
        logic [W-1:0] a_cap, b_cap;
        rinv = 0;
        for (int x = 1; x < MOD; x++) if (((256 * x) % MOD) == 1) rinv = x;
        mm_done_m = 1'b0;
        mm_res = '0;
        forever begin
            @(negedge clk);
            if (mm_start === 1'b1 && !rst) begin
                a_cap = mm_a;
                b_cap = mm_b;
                lat = lat_rand ? int'($urandom_range(20, 1)) : 3;
                abort = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    #1;
                    if (rst) abort = 1'b1;
                    else if (mm_a !== a_cap || mm_b !== b_cap) stab_bad++;
                end
                if (!abort) begin
                    mm_done_m = 1'b1;
                    mm_res = W'((longint'(a_cap) * longint'(b_cap) * longint'(rinv)) % MOD);
                    @(posedge clk);
                    #1;
                    mm_done_m = 1'b0;
                end
            end
        end
    end

    task automatic run_job(input string name, input logic [7:0] c, input logic [7:0] e,
                           input int exp_res, input int exp_mm, input bit disturb);
        int mm0 = mm_pulses;
        int cs0 = cs_pulses;
        int d0  = done_pulses;
        int ov0 = overlap;
        int st0 = stab_bad;
        int busy_bad = 0;
        int after_bad = 0;
        bit got = 1'b0;
        @(negedge clk);
        M_in = 8'(MOD);
        C_in = c;
        E_in = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (disturb && cyc == 1) begin
                start = 1'b1;
                C_in = 8'd5;
                E_in = 8'h03;
                mm_spur = 1'b1;
            end else if (disturb && cyc == 2) begin
                start = 1'b0;
                mm_spur = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                if (!busy) busy_bad++;
                if (disturb) start = 1'b1;
                break;
            end
            if (!busy) busy_bad++;
            @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) after_bad++;
            @(negedge clk);
        end
        $display("JOB %s C=%0d E=%02h result=%0d mm_ops=%0d const_ops=%0d",
                 name, c, e, result, mm_pulses - mm0, cs_pulses - cs0);
        check({name, "_done_seen"}, got, 1);
        check({name, "_result"}, result, exp_res);
        check({name, "_mm_pulses"}, mm_pulses - mm0, exp_mm);
        check({name, "_const_pulses"}, cs_pulses - cs0, 1);
        check({name, "_done_pulses"}, done_pulses - d0, 1);
        check({name, "_busy_window"}, busy_bad, 0);
        check({name, "_idle_after"}, after_bad, 0);
        check({name, "_operand_stable"}, stab_bad - st0, 0);
        check({name, "_start_overlap"}, overlap - ov0, 0);
    endtask

    typedef struct {
        logic [7:0] c;
        logic [7:0] e;
        int         exp_res;
        int         exp_mm;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int mm0;
        bit reached;
        logic [7:0] rc, re;

        vecs[0] = '{c: 8'd2, e: 8'h07, exp_res: 128, exp_mm: 13};
        vecs[1] = '{c: 8'd5, e: 8'h03, exp_res: 125, exp_mm: 12};
        vecs[2] = '{c: 8'd5, e: 8'h00, exp_res: 1,   exp_mm: 10};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_mm_start", mm_start, 0);
        check("reset_const_start", const_start, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            run_job($sformatf("vec%0d", v), vecs[v].c, vecs[v].e,
                    vecs[v].exp_res, vecs[v].exp_mm, 1'b0);
        end

        // Re-pulsed start while busy, spurious mm_done in C_WAIT, start in FIN.
        run_job("disturb", 8'd2, 8'h07, 128, 13, 1'b1);

        // Reset in the middle of a squaring step.
        mm0 = mm_pulses;
        @(negedge clk);
        C_in = 8'd2;
        E_in = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (mm_pulses - mm0 >= 2) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reached_sqr", reached, 1);
        rst = 1'b1;
        #1;
        $display("MIDRST result=%0d M_r=%0d mm_a=%0d mm_b=%0d busy=%0d", result, M_r, mm_a, mm_b, busy);
        check("midrst_result", result, 0);
        check("midrst_M_r", M_r, 0);
        check("midrst_mm_a", mm_a, 0);
        check("midrst_mm_b", mm_b, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_mm_start", mm_start, 0);
        check("midrst_const_start", const_start, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_idle", busy, 0);
        run_job("post_rst", 8'd2, 8'h07, 128, 13, 1'b0);

        // Random operands with random multiplier latency.
        lat_rand = 1'b1;
        for (int n = 0; n < 8; n++) begin
            rc = 8'($urandom_range(MOD - 1, 0));
            re = 8'($urandom_range(255, 0));
            run_job($sformatf("rand%0d", n), rc, re, ref_modexp(int'(rc), int'(re)),
                    2 + E_W + $countones(re), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
